// File: rtl/time_set_editor_pkg.sv
// time_set_editor_pkg
//   Shared definitions for the time-setting editor and the time register:
//   editor FSM state encodings, BCD field thresholds and wrap targets, and
//   the BCD increment / wrap-decision helpers.
package time_set_editor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_EDIT_HOURS   = 3'd1,
        ST_EDIT_MINUTES = 3'd2,
        ST_EDIT_SECONDS = 3'd3,
        ST_COMMIT       = 3'd4
    } edit_state_e;

    // Highest legal value of each field; reaching it wraps to the target
    localparam logic [7:0] HOURS_THRESH_12 = 8'h12;
    localparam logic [7:0] HOURS_THRESH_24 = 8'h23;
    localparam logic [7:0] MINSEC_THRESH   = 8'h59;

    localparam logic [7:0] HOURS_WRAP_12   = 8'h01;
    localparam logic [7:0] HOURS_WRAP_24   = 8'h00;
    localparam logic [7:0] MINSEC_WRAP     = 8'h00;

    // Two-digit BCD increment: a low digit of 9 (or anything above) rolls to 0
    // and carries into the high digit.
    function automatic logic [7:0] inc_bcd(input logic [7:0] value);
        logic [7:0] result;
        if (value[3:0] >= 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

    // True when the field is at (or, if corrupted, beyond) its threshold.
    function automatic logic should_wrap(input logic [7:0] value,
                                         input logic [7:0] threshold);
        return (value[7:4] > threshold[7:4]) ||
               ((value[7:4] == threshold[7:4]) && (value[3:0] >= threshold[3:0]));
    endfunction

endpackage

// File: rtl/time_set_editor_bcd_field_inc.sv
// bcd_field_inc
//   Combinational next value of one two-digit BCD time field.
//   Ports:
//     value_bcd     in  8  current field value
//     threshold_bcd in  8  value at which the field wraps
//     wrap_bcd      in  8  value loaded on wrap
//     next_bcd      out 8  incremented or wrapped value
module bcd_field_inc
    import time_set_editor_pkg::*;
(
    input  logic [7:0] value_bcd,
    input  logic [7:0] threshold_bcd,
    input  logic [7:0] wrap_bcd,
    output logic [7:0] next_bcd
);

    // Wrap takes precedence over the plain BCD increment
    always_comb begin
        if (should_wrap(value_bcd, threshold_bcd)) begin
            next_bcd = wrap_bcd;
        end else begin
            next_bcd = inc_bcd(value_bcd);
        end
    end

endmodule

// File: rtl/time_set_editor.sv
// time_set_editor
//   Lets the user edit hh:mm:ss with two buttons. btn_select enters edit mode
//   and steps hours -> minutes -> seconds -> commit; btn_adjust increments the
//   selected field of a shadow copy. Commit pulses load_new with the edited
//   time; inactivity for TIMEOUT_TICKS blink ticks abandons the edit.
//   Ports:
//     clk, reset          in   1  clock, synchronous active-high reset
//     current_time_bcd    in  24  running time {hh,mm,ss}
//     btn_select          in   1  enter edit / next field pulse
//     btn_adjust          in   1  increment field pulse
//     blink_tick          in   1  ~2 Hz pulse for blink and timeout
//     time_to_load_bcd    out 24  edited time (shadow register)
//     load_new            out  1  one-cycle commit strobe
//     editing             out  1  editor is not idle
//     field_blank         out  3  {hours,minutes,seconds} blank request
//     display_time_bcd    out 24  shadow while editing, else running time
module time_set_editor
    import time_set_editor_pkg::*;
#(
    parameter int HOURS_STYLE_AMERICAN = 1,
    parameter int TIMEOUT_TICKS        = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] current_time_bcd,
    input  logic        btn_select,
    input  logic        btn_adjust,
    input  logic        blink_tick,
    output logic [23:0] time_to_load_bcd,
    output logic        load_new,
    output logic        editing,
    output logic [2:0]  field_blank,
    output logic [23:0] display_time_bcd
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_TICKS);

    localparam logic [7:0] HOURS_THRESH = (HOURS_STYLE_AMERICAN != 0) ? HOURS_THRESH_12 : HOURS_THRESH_24;
    localparam logic [7:0] HOURS_WRAP   = (HOURS_STYLE_AMERICAN != 0) ? HOURS_WRAP_12   : HOURS_WRAP_24;

    edit_state_e   state_q, state_d;
    logic [23:0]   shadow_q, shadow_d;
    logic          blink_phase_q, blink_phase_d;
    logic [TW-1:0] timeout_q, timeout_d;

    logic [7:0]    field_val_s;
    logic [7:0]    field_th_s;
    logic [7:0]    field_wrap_s;
    logic [7:0]    field_next_s;
    logic [TW-1:0] timeout_inc_s;
    logic          editing_s;

    assign timeout_inc_s = timeout_q + TW'(1);
    assign editing_s     = (state_q != ST_IDLE);

    // Select the field being edited so one incrementer serves all three
    always_comb begin
        field_val_s  = 8'h00;
        field_th_s   = MINSEC_THRESH;
        field_wrap_s = MINSEC_WRAP;
        case (state_q)
            ST_EDIT_HOURS: begin
                field_val_s  = shadow_q[23:16];
                field_th_s   = HOURS_THRESH;
                field_wrap_s = HOURS_WRAP;
            end
            ST_EDIT_MINUTES: begin
                field_val_s  = shadow_q[15:8];
            end
            ST_EDIT_SECONDS: begin
                field_val_s  = shadow_q[7:0];
            end
            default: begin
                field_val_s  = 8'h00;
            end
        endcase
    end

    bcd_field_inc u_field_inc (
        .value_bcd     (field_val_s),
        .threshold_bcd (field_th_s),
        .wrap_bcd      (field_wrap_s),
        .next_bcd      (field_next_s)
    );

    // Next-state, shadow, blink-phase and timeout logic
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        blink_phase_d = blink_phase_q;
        timeout_d     = timeout_q;
        case (state_q)
            ST_IDLE: begin
                blink_phase_d = 1'b0;
                timeout_d     = '0;
                if (btn_select) begin
                    shadow_d = current_time_bcd;
                    state_d  = ST_EDIT_HOURS;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EDIT_HOURS, ST_EDIT_MINUTES, ST_EDIT_SECONDS: begin
                // select beats adjust; any button beats a blink tick
                if (btn_select) begin
                    blink_phase_d = 1'b0;
                    timeout_d     = '0;
                    case (state_q)
                        ST_EDIT_HOURS:   state_d = ST_EDIT_MINUTES;
                        ST_EDIT_MINUTES: state_d = ST_EDIT_SECONDS;
                        default:         state_d = ST_COMMIT;
                    endcase
                end else if (btn_adjust) begin
                    blink_phase_d = 1'b0;
                    timeout_d     = '0;
                    case (state_q)
                        ST_EDIT_HOURS:   shadow_d[23:16] = field_next_s;
                        ST_EDIT_MINUTES: shadow_d[15:8]  = field_next_s;
                        default:         shadow_d[7:0]   = field_next_s;
                    endcase
                end else if (blink_tick) begin
                    if (timeout_inc_s >= TIMEOUT_LIMIT) begin
                        // abandon: no commit, shadow discarded
                        state_d       = ST_IDLE;
                        shadow_d      = 24'h00_00_00;
                        blink_phase_d = 1'b0;
                        timeout_d     = '0;
                    end else begin
                        blink_phase_d = ~blink_phase_q;
                        timeout_d     = timeout_inc_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_COMMIT: begin
                state_d       = ST_IDLE;
                blink_phase_d = 1'b0;
                timeout_d     = '0;
            end
            default: begin
                state_d       = ST_IDLE;
                blink_phase_d = 1'b0;
                timeout_d     = '0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shadow_q      <= 24'h00_00_00;
            blink_phase_q <= 1'b0;
            timeout_q     <= '0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            blink_phase_q <= blink_phase_d;
            timeout_q     <= timeout_d;
        end
    end

    // Blink request only on the field currently being edited
    always_comb begin
        field_blank = 3'b000;
        case (state_q)
            ST_EDIT_HOURS:   field_blank = {blink_phase_q, 2'b00};
            ST_EDIT_MINUTES: field_blank = {1'b0, blink_phase_q, 1'b0};
            ST_EDIT_SECONDS: field_blank = {2'b00, blink_phase_q};
            default:         field_blank = 3'b000;
        endcase
    end

    // Reset in the commit cycle suppresses the strobe
    assign load_new         = (state_q == ST_COMMIT) && !reset;
    assign time_to_load_bcd = shadow_q;
    assign editing          = editing_s;
    assign display_time_bcd = editing_s ? shadow_q : current_time_bcd;

endmodule
